// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer BRAM arbiter: the VGA reader always wins the port, and
// camera writes are buffered in a small FIFO that drains in cycles the reader leaves free.
module fb_port_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 9,
    parameter int FB_SIZE      = 307200,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 800
) (
    input  logic                          i_clk25m,
    input  logic                          i_rst_clk25m,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_rd_valid,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_starved,
    output logic                          o_wr_oor
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FB_SIZE_L = ADDR_W'(FB_SIZE);
    localparam logic [CNT_W-1:0]  LIMIT_L   = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                init_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                starved_q, starved_d;
    logic                oor_q, oor_d;

    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];

    logic                fifo_empty_s;
    logic                head_oor_s;
    logic                push_s;
    logic                pop_s;
    logic [ADDR_W-1:0]   head_addr_s;
    logic [DATA_W-1:0]   head_data_s;

    // init_q keeps the writer throttled during reset and for the first cycle after it
    assign o_wr_ready   = init_q && (level_q < DEPTH_L);
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_valid_q ? i_mem_rdata : {DATA_W{1'b0}};
    assign o_mem_en     = mem_en_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_fifo_level = level_q;
    assign o_starved    = starved_q;
    assign o_wr_oor     = oor_q;

    // Port-op selection, FIFO bookkeeping, stall counter and sticky flags
    always_comb begin
        fifo_empty_s = (level_q == {LVL_W{1'b0}});
        head_addr_s  = fifo_addr_q[rd_ptr_q];
        head_data_s  = fifo_data_q[rd_ptr_q];
        head_oor_s   = !fifo_empty_s && (head_addr_s >= FB_SIZE_L);
        push_s       = i_wr_valid && o_wr_ready;
        pop_s        = 1'b0;
        state_d      = ST_IDLE;
        mem_addr_d   = {ADDR_W{1'b0}};
        mem_wdata_d  = {DATA_W{1'b0}};
        oor_d        = oor_q;

        if (i_rd_req) begin
            state_d    = ST_RD;
            mem_addr_d = i_rd_addr;
        end else if (!fifo_empty_s && !head_oor_s) begin
            state_d     = ST_WR;
            pop_s       = 1'b1;
            mem_addr_d  = head_addr_s;
            mem_wdata_d = head_data_s;
        end else begin
            state_d = ST_IDLE;
        end

        // An out-of-range head never needs the port, so it is discarded even under reads
        if (head_oor_s) begin
            pop_s = 1'b1;
            oor_d = 1'b1;
        end else begin
            oor_d = oor_q;
        end

        mem_en_d   = (state_d != ST_IDLE);
        mem_we_d   = (state_d == ST_WR);
        rd_valid_d = (state_q == ST_RD);

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (pop_s || fifo_empty_s) begin
            stall_d = {CNT_W{1'b0}};
        end else if (i_rd_req && (stall_q != LIMIT_L)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        starved_d = starved_q || (stall_d == LIMIT_L);
    end

    // Control and status registers
    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m) begin
            state_q     <= ST_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
            init_q      <= 1'b0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            stall_q     <= {CNT_W{1'b0}};
            starved_q   <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_valid_q  <= rd_valid_d;
            init_q      <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            stall_q     <= stall_d;
            starved_q   <= starved_d;
            oor_q       <= oor_d;
        end
    end

    // FIFO payload storage; contents are meaningless while level is zero
    always_ff @(posedge i_clk25m) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= i_wr_addr;
            fifo_data_q[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a 1-cycle-latency BRAM model.
module tb_fb_port_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [2:0]        fifo_level;
    logic              starved, wr_oor;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] bram [0:1023];

    fb_port_arbiter dut (
        .i_clk25m(clk), .i_rst_clk25m(rst),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_fifo_level(fifo_level), .o_starved(starved), .o_wr_oor(wr_oor)
    );

    always #5 clk = ~clk;

    // BRAM model: read data appears the cycle after the enable and then holds
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_en_we: got %b want 00", {mem_en, mem_we}); end
        checks++; if (mem_addr !== 19'd0 || mem_wdata !== 9'd0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 9'd0) begin errors++; $display("FAIL reset_rd: got %b/%h want 0/0", rd_valid, rd_data); end
        checks++; if (fifo_level !== 3'd0 || wr_ready !== 1'b0) begin errors++; $display("FAIL reset_fifo: level %0d ready %b want 0/0", fifo_level, wr_ready); end
        checks++; if (starved !== 1'b0 || wr_oor !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b want 0/0", starved, wr_oor); end
        rst = 1'b0;
        tick();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_single_read();
        bram[100] = 9'h1A5;
        rd_req = 1'b1; rd_addr = 19'd100;
        tick();
        rd_req = 1'b0;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'd100) begin errors++; $display("FAIL read_op: en %b we %b addr %0d want 1 0 100", mem_en, mem_we, mem_addr); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %b want 0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 9'h1A5) begin errors++; $display("FAIL read_data: valid %b data %h want 1 1a5", rd_valid, rd_data); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL read_idle_after: en %b want 0", mem_en); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 9'd0) begin errors++; $display("FAIL read_data_mask: valid %b data %h want 0 0", rd_valid, rd_data); end
    endtask

    task automatic test_write_idle();
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 9'h0F;
        tick();
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL wr_level1: got %0d want 1", fifo_level); end
        wr_addr = 19'd6; wr_data = 9'h10;
        tick();
        wr_valid = 1'b0;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd5 || mem_wdata !== 9'h0F) begin errors++; $display("FAIL wr_op5: en %b we %b addr %0d data %h want 1 1 5 0f", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL wr_level_peak: got %0d want 1", fifo_level); end
        tick();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd6 || mem_wdata !== 9'h10) begin errors++; $display("FAIL wr_op6: en %b we %b addr %0d data %h want 1 1 6 10", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL wr_level0: got %0d want 0", fifo_level); end
        tick();
        checks++; if (mem_en !== 1'b0 || bram[5] !== 9'h0F || bram[6] !== 9'h10) begin errors++; $display("FAIL wr_contents: en %b m5 %h m6 %h want 0 0f 10", mem_en, bram[5], bram[6]); end
    endtask

    task automatic test_contention();
        int sent = 0;
        int we_during_reads = 0;
        int n_ops = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        int order_bad = 0;
        logic acc;
        for (int c = 0; c < 10; c++) begin
            rd_req = 1'b1; rd_addr = 19'd200;
            wr_valid = (sent < 6);
            wr_addr = 19'(10 + sent); wr_data = 9'(9'h20 + sent);
            acc = wr_valid && wr_ready;
            tick();
            if (acc) sent++;
            if (mem_we !== 1'b0 || mem_en !== 1'b1) we_during_reads++;
        end
        checks++; if (sent != 4) begin errors++; $display("FAIL cont_accepted: got %0d want 4", sent); end
        checks++; if (wr_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL cont_full: ready %b level %0d want 0 4", wr_ready, fifo_level); end
        rd_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            wr_valid = (sent < 6);
            wr_addr = 19'(10 + sent); wr_data = 9'(9'h20 + sent);
            acc = wr_valid && wr_ready;
            tick();
            if (acc) sent++;
            if (mem_en === 1'b1 && mem_we === 1'b1) begin
                if (mem_addr !== 19'(10 + n_ops) || mem_wdata !== 9'(9'h20 + n_ops)) order_bad++;
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                n_ops++;
            end
        end
        wr_valid = 1'b0;
        checks++; if (we_during_reads != 0) begin errors++; $display("FAIL cont_no_wr_during_rd: got %0d bad cycles want 0", we_during_reads); end
        checks++; if (n_ops != 6 || order_bad != 0) begin errors++; $display("FAIL cont_wr_order: ops %0d misordered %0d want 6 0", n_ops, order_bad); end
        checks++; if (first_cyc != 0 || last_cyc != 5) begin errors++; $display("FAIL cont_wr_timing: first %0d last %0d want 0 5", first_cyc, last_cyc); end
        checks++; if (fifo_level !== 3'd0 || bram[15] !== 9'h25) begin errors++; $display("FAIL cont_drained: level %0d m15 %h want 0 25", fifo_level, bram[15]); end
    endtask

    task automatic test_starvation();
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_pre: got %b want 0", starved); end
        rd_req = 1'b1; rd_addr = 19'd300;
        wr_valid = 1'b1; wr_addr = 19'd40; wr_data = 9'h33;
        tick();
        wr_valid = 1'b0;
        for (int c = 0; c < 799; c++) tick();
        checks++; if (starved !== 1'b0 || fifo_level !== 3'd1) begin errors++; $display("FAIL starve_early: starved %b level %0d want 0 1", starved, fifo_level); end
        tick();
        checks++; if (starved !== 1'b1) begin errors++; $display("FAIL starve_set: got %b want 1", starved); end
        rd_req = 1'b0;
        tick(); tick(); tick();
        checks++; if (starved !== 1'b1 || fifo_level !== 3'd0 || bram[40] !== 9'h33) begin errors++; $display("FAIL starve_sticky: starved %b level %0d m40 %h want 1 0 33", starved, fifo_level, bram[40]); end
    endtask

    task automatic test_oor();
        bram[0] = 9'h000;
        checks++; if (wr_oor !== 1'b0) begin errors++; $display("FAIL oor_pre: got %b want 0", wr_oor); end
        wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 9'h55;
        tick();
        wr_addr = 19'd0; wr_data = 9'h66;
        tick();
        wr_valid = 1'b0;
        checks++; if (mem_en !== 1'b0 || wr_oor !== 1'b1) begin errors++; $display("FAIL oor_dropped: en %b oor %b want 0 1", mem_en, wr_oor); end
        tick();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd0 || mem_wdata !== 9'h66) begin errors++; $display("FAIL oor_next_wr: en %b we %b addr %0d data %h want 1 1 0 66", mem_en, mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (wr_oor !== 1'b1 || fifo_level !== 3'd0) begin errors++; $display("FAIL oor_sticky: oor %b level %0d want 1 0", wr_oor, fifo_level); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        rd_req = 1'b1; rd_addr = 19'd100;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(50 + i); wr_data = 9'(9'h40 + i);
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (fifo_level !== 3'd3 || rd_valid !== 1'b1 || mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_setup: level %0d valid %b en %b want 3 1 1", fifo_level, rd_valid, mem_en); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({mem_en, mem_we, rd_valid, wr_ready, starved, wr_oor} !== 6'b0) begin errors++; $display("FAIL rstmid_ctrl: en/we/valid/ready/starved/oor %b want 000000", {mem_en, mem_we, rd_valid, wr_ready, starved, wr_oor}); end
        checks++; if (mem_addr !== 19'd0 || mem_wdata !== 9'd0 || rd_data !== 9'd0 || fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_data: addr %0d wdata %h rdata %h level %0d want 0", mem_addr, mem_wdata, rd_data, fifo_level); end
        rd_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rd_valid !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d active cycles want 0", bad); end
        checks++; if (wr_ready !== 1'b1 || fifo_level !== 3'd0 || bram[50] !== 9'h000) begin errors++; $display("FAIL rstmid_after: ready %b level %0d m50 %h want 1 0 0", wr_ready, fifo_level, bram[50]); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bram[i] = 9'd0;
        test_reset();
        test_single_read();
        test_write_idle();
        test_contention();
        test_starvation();
        test_oor();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
